// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port: one-cycle request strobe with address,
// variable-latency single-cycle response strobe with data.
interface instruction_fetch_unit_if #(
  parameter int PC_WIDTH   = 12,
  parameter int INST_WIDTH = 19
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [INST_WIDTH-1:0] imem_rdata;
  logic                  imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC and fetch stage: requests one instruction at a time from a variable-latency
// memory, holds it for the decoder, and advances the PC from the decoder selects.
module instruction_fetch_unit #(
  parameter int                  PC_WIDTH     = 12,
  parameter int                  INST_WIDTH   = 19,
  parameter int                  OFFSET_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = {PC_WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel_PCSrc_plus1,
  input  logic                    sel_PCSrc_offset,
  input  logic                    sel_PCSrc_const,
  input  logic                    branch_taken,
  input  logic [OFFSET_WIDTH-1:0] jump_offset,
  input  logic [PC_WIDTH-1:0]     jump_const,
  input  logic                    stall,
  instruction_fetch_unit_if.master imem,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [INST_WIDTH-1:0]   instruction,
  output logic [5:0]              opcode,
  output logic                    instruction_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic [PC_WIDTH-1:0]     pc_r;
  logic [INST_WIDTH-1:0]   instruction_r;
  logic                    instruction_valid_r;
  logic                    imem_req_r;
  logic [PC_WIDTH-1:0]     next_pc_s;

  // Offset is relative to the current instruction's PC; all sums wrap modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] calc_next_pc(
    input logic [PC_WIDTH-1:0]     cur_pc,
    input logic                    sel_plus1,
    input logic                    sel_offset,
    input logic                    sel_const,
    input logic                    taken,
    input logic [OFFSET_WIDTH-1:0] offset,
    input logic [PC_WIDTH-1:0]     target
  );
    logic [PC_WIDTH-1:0] offset_ext;
    offset_ext = {{(PC_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};
    if (sel_const) begin
      return target;
    end else if (sel_offset && taken) begin
      return cur_pc + offset_ext;
    end else if (sel_plus1) begin
      return cur_pc + PC_ONE;
    end else begin
      return cur_pc + PC_ONE;
    end
  endfunction

  // Next-PC selection from decoder selects and branch condition
  always_comb begin
    next_pc_s = calc_next_pc(pc_r, sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const,
                             branch_taken, jump_offset, jump_const);
  end

  // Fetch FSM; imem_req is set on entry to REQ so it is high for exactly that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r             <= S_IDLE;
      pc_r                <= RESET_PC;
      instruction_r       <= {INST_WIDTH{1'b0}};
      instruction_valid_r <= 1'b0;
      imem_req_r          <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          imem_req_r <= 1'b1;
          state_r    <= S_REQ;
        end
        S_REQ: begin
          imem_req_r <= 1'b0;
          state_r    <= S_WAIT;
        end
        S_WAIT: begin
          imem_req_r <= 1'b0;
          if (imem.imem_valid) begin
            instruction_r       <= imem.imem_rdata;
            instruction_valid_r <= 1'b1;
            state_r             <= S_ISSUE;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_ISSUE: begin
          if (stall) begin
            imem_req_r <= 1'b0;
            state_r    <= S_ISSUE;
          end else begin
            pc_r                <= next_pc_s;
            instruction_valid_r <= 1'b0;
            imem_req_r          <= 1'b1;
            state_r             <= S_REQ;
          end
        end
        default: begin
          state_r             <= S_IDLE;
          instruction_valid_r <= 1'b0;
          imem_req_r          <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req     = imem_req_r;
  assign imem.imem_addr    = pc_r;
  assign pc                = pc_r;
  assign instruction       = instruction_r;
  assign opcode            = instruction_r[INST_WIDTH-1 -: 6];
  assign instruction_valid = instruction_valid_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: the bench plays the instruction
// memory and the decoder, and checks fetch addresses, timing and held outputs.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_plus1;
  logic        sel_offset;
  logic        sel_const;
  logic        branch_taken;
  logic [7:0]  jump_offset;
  logic [11:0] jump_const;
  logic        stall;
  logic [11:0] pc;
  logic [18:0] instruction;
  logic [5:0]  opcode;
  logic        instruction_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.PC_WIDTH(12), .INST_WIDTH(19)) imem_bus ();

  instruction_fetch_unit #(
    .PC_WIDTH(12), .INST_WIDTH(19), .OFFSET_WIDTH(8), .RESET_PC(12'h000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .sel_PCSrc_plus1  (sel_plus1),
    .sel_PCSrc_offset (sel_offset),
    .sel_PCSrc_const  (sel_const),
    .branch_taken     (branch_taken),
    .jump_offset      (jump_offset),
    .jump_const       (jump_const),
    .stall            (stall),
    .imem             (imem_bus.master),
    .pc               (pc),
    .instruction      (instruction),
    .opcode           (opcode),
    .instruction_valid(instruction_valid)
  );

  // Memory contents: opcode field = addr[5:0]^0x2A, then a 1, then the address
  function automatic logic [18:0] mem_word(input logic [11:0] a);
    return {a[5:0] ^ 6'h2A, 1'b1, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic set_sel(input logic p1, input logic off, input logic cst, input logic tk,
                         input logic [7:0] jo, input logic [11:0] jc);
    sel_plus1    = p1;
    sel_offset   = off;
    sel_const    = cst;
    branch_taken = tk;
    jump_offset  = jo;
    jump_const   = jc;
  endtask

  // Wait for a request (expected one cycle after the previous ISSUE), respond
  // after lat cycles, and check the issued instruction.
  task automatic fetch(input logic [11:0] exp_addr, input int lat, input string tag);
    int          cyc;
    logic [11:0] addr;
    logic [18:0] w;
    cyc  = 0;
    addr = 12'hxxx;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (imem_bus.imem_req === 1'b1) begin
        addr = imem_bus.imem_addr;
        break;
      end
    end
    chk({tag, " req_cycles"}, cyc, 1);
    chk({tag, " addr"}, {20'h0, addr}, {20'h0, exp_addr});
    w = mem_word(exp_addr);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({tag, " wait_valid"}, {31'h0, instruction_valid}, 32'h0);
        chk({tag, " wait_req"}, {31'h0, imem_bus.imem_req}, 32'h0);
      end
    end
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = w;
    @(negedge clk);
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 19'h0;
    chk({tag, " valid"}, {31'h0, instruction_valid}, 32'h1);
    chk({tag, " instr"}, {13'h0, instruction}, {13'h0, w});
    chk({tag, " opcode"}, {26'h0, opcode}, {26'h0, exp_addr[5:0] ^ 6'h2A});
    chk({tag, " pc"}, {20'h0, pc}, {20'h0, exp_addr});
  endtask

  initial begin
    rst                 = 1'b1;
    stall               = 1'b0;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 19'h0;
    set_sel(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
    repeat (2) @(negedge clk);
    chk("rst pc", {20'h0, pc}, 32'h0);
    chk("rst instr", {13'h0, instruction}, 32'h0);
    chk("rst valid", {31'h0, instruction_valid}, 32'h0);
    chk("rst req", {31'h0, imem_bus.imem_req}, 32'h0);

    // Linear fetch, latency 1: one request every 3 cycles
    rst = 1'b0;
    set_sel(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
    fetch(12'h000, 1, "lin0");
    fetch(12'h001, 1, "lin1");
    fetch(12'h002, 1, "lin2");
    fetch(12'h003, 1, "lin3");
    set_sel(1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 12'h000);
    fetch(12'h005, 1, "off+2");

    // Const beats offset when both are asserted
    set_sel(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 12'h123);
    fetch(12'h123, 1, "const");
    set_sel(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 12'h010);
    fetch(12'h010, 1, "const010");
    set_sel(1'b0, 1'b1, 1'b0, 1'b1, 8'hF8, 12'h000);
    fetch(12'h008, 1, "off-8 taken");
    set_sel(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 12'h010);
    fetch(12'h010, 1, "const010b");
    set_sel(1'b0, 1'b1, 1'b0, 1'b0, 8'hF8, 12'h000);
    fetch(12'h011, 1, "off-8 not taken");

    // Wrap-around in both directions
    set_sel(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 12'hFFF);
    fetch(12'hFFF, 1, "constFFF");
    set_sel(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
    fetch(12'h000, 1, "wrap+1");
    set_sel(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 12'h002);
    fetch(12'h002, 1, "const002");
    set_sel(1'b0, 1'b1, 1'b0, 1'b1, 8'hFC, 12'h000);
    fetch(12'hFFE, 1, "wrap-4");
    set_sel(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
    fetch(12'hFFF, 4, "nosel lat4");

    // Stall in ISSUE for 5 cycles: everything held, no request
    stall = 1'b1;
    set_sel(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 12'h055);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall pc", {20'h0, pc}, 32'h0000_0FFF);
      chk("stall instr", {13'h0, instruction}, {13'h0, mem_word(12'hFFF)});
      chk("stall opcode", {26'h0, opcode}, 32'h15);
      chk("stall req", {31'h0, imem_bus.imem_req}, 32'h0);
      chk("stall valid", {31'h0, instruction_valid}, 32'h1);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("release req", {31'h0, imem_bus.imem_req}, 32'h1);
    chk("release addr", {20'h0, imem_bus.imem_addr}, 32'h055);
    @(negedge clk);
    chk("release one update", {20'h0, pc}, 32'h055);
    chk("release wait req", {31'h0, imem_bus.imem_req}, 32'h0);

    // Reset while WAIT is pending, then a stray response in IDLE
    rst = 1'b1;
    @(negedge clk);
    chk("midrst pc", {20'h0, pc}, 32'h0);
    chk("midrst instr", {13'h0, instruction}, 32'h0);
    chk("midrst req", {31'h0, imem_bus.imem_req}, 32'h0);
    rst                 = 1'b0;
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = mem_word(12'h055);
    @(negedge clk);
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 19'h0;
    chk("stray instr", {13'h0, instruction}, 32'h0);
    chk("stray valid", {31'h0, instruction_valid}, 32'h0);
    chk("post-rst req", {31'h0, imem_bus.imem_req}, 32'h1);
    chk("post-rst addr", {20'h0, imem_bus.imem_addr}, 32'h0);
    @(negedge clk);
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = mem_word(12'h000);
    @(negedge clk);
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 19'h0;
    chk("post-rst instr", {13'h0, instruction}, {13'h0, mem_word(12'h000)});
    chk("post-rst valid", {31'h0, instruction_valid}, 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
